// File: rtl/mem_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mem_bus_arbiter
//
// Shares the single external memory bus (cartridge ROM/RAM, VRAM, WRAM, OAM)
// between the CPU, the OAM DMA engine and the HDMA block-transfer engine.
// Ownership only changes on the last T-cycle of a machine cycle (ct == 2'b11),
// so an access in flight is never cut short.
//
// While OAM DMA owns the bus the CPU keeps running. Its reads below FF00 return
// conflict data, and its writes below FF00 are dropped. While HDMA owns the bus
// the CPU is halted. HDMA is limited to HDMA_MAX_MCYC consecutive machine
// cycles, after which the CPU gets one machine cycle before HDMA may resume.
//
// Parameters:
//   HDMA_MAX_MCYC  consecutive HDMA machine cycles before a forced CPU slot
//                  (1..255)
//   CONFLICT_DATA  byte returned to CPU reads that OAM DMA blocks
//
// Optional build macro:
//   BUS_ARB_DMG_CORRUPT_EN  when defined, blocked CPU reads during OAM DMA
//                           return bus_din, the byte DMA is currently reading,
//                           instead of CONFLICT_DATA. Blocked writes are dropped
//                           in either build.
//
// Ports:
//   clk, rst          system clock, synchronous active-high reset
//   ct                T-cycle phase, 2'b11 is the last phase of a machine cycle
//   cpu_*             CPU strobes/address/data, cpu_din returned read data,
//                     cpu_halt stalls the CPU clock-enable
//   io_din            read data from the IO/HRAM decoder (FF00-FFFF)
//   dma_*             OAM DMA request (dma_occupy), strobes, address, data
//   hdma_*            HDMA request/grant, strobes, address, data
//   bus_*             memory bus towards the memory decoder
// -----------------------------------------------------------------------------
module mem_bus_arbiter #(
    parameter int unsigned HDMA_MAX_MCYC = 16,
    parameter logic [7:0]  CONFLICT_DATA = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  ct,

    input  logic        cpu_rd,
    input  logic        cpu_wr,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    output logic        cpu_halt,

    input  logic [7:0]  io_din,

    input  logic        dma_occupy,
    input  logic        dma_rd,
    input  logic        dma_wr,
    input  logic [15:0] dma_a,
    input  logic [7:0]  dma_dout,
    output logic [7:0]  dma_din,

    input  logic        hdma_req,
    output logic        hdma_gnt,
    input  logic        hdma_rd,
    input  logic        hdma_wr,
    input  logic [15:0] hdma_a,
    input  logic [7:0]  hdma_dout,
    output logic [7:0]  hdma_din,

    output logic        bus_rd,
    output logic        bus_wr,
    output logic [15:0] bus_a,
    output logic [7:0]  bus_dout,
    input  logic [7:0]  bus_din
);

    typedef enum logic [1:0] {
        OWN_CPU  = 2'd0,
        OWN_OAM  = 2'd1,
        OWN_HDMA = 2'd2
    } owner_e;

    localparam logic [7:0]  STREAK_MAX = 8'(HDMA_MAX_MCYC);
    localparam logic [15:0] IO_BASE    = 16'hFF00;

    owner_e     owner_q,    owner_d;
    logic [7:0] streak_q,   streak_d;
    logic       hdma_gnt_q, hdma_gnt_d;
    logic       cpu_halt_q, cpu_halt_d;

    logic       boundary;
    logic       streak_done;
    logic       cpu_in_io;

    assign boundary    = (ct == 2'b11);
    // The streak counts HDMA machine cycles in the current stint, so reaching
    // the limit means HDMA has just used its last permitted machine cycle.
    assign streak_done = (streak_q >= STREAK_MAX);
    // FF00-FFFF is served by the internal IO/HRAM decoder, never by the bus.
    assign cpu_in_io   = (cpu_a >= IO_BASE);

    // -------------------------------------------------------------------------
    // Arbitration, evaluated only at machine-cycle boundaries.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        owner_d    = owner_q;
        streak_d   = streak_q;
        hdma_gnt_d = hdma_gnt_q;
        cpu_halt_d = cpu_halt_q;

        if (boundary) begin
            if (dma_occupy) begin
                owner_d = OWN_OAM;
            end else if (hdma_req && !streak_done) begin
                owner_d = OWN_HDMA;
            end else begin
                owner_d = OWN_CPU;
            end

            // Counts every boundary that hands the next machine cycle to HDMA,
            // and clears whenever that cycle goes to anyone else (forced CPU
            // slot, OAM preemption or HDMA finishing).
            if (owner_d == OWN_HDMA) begin
                streak_d = streak_q + 8'd1;
            end else begin
                streak_d = 8'd0;
            end

            hdma_gnt_d = (owner_d == OWN_HDMA);

            // The CPU halt follows HDMA ownership. It is held through an OAM
            // preemption of a still-pending HDMA, because HDMA takes the bus
            // back as soon as OAM DMA lets go. OAM DMA alone never halts the
            // CPU, which keeps running and sees conflict data.
            cpu_halt_d = (owner_d == OWN_HDMA) ||
                         ((owner_d == OWN_OAM) && cpu_halt_q && hdma_req);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge values and the evaluation order does not matter.
        if (rst) begin
            owner_q    <= OWN_CPU;
            streak_q   <= 8'd0;
            hdma_gnt_q <= 1'b0;
            cpu_halt_q <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            streak_q   <= streak_d;
            hdma_gnt_q <= hdma_gnt_d;
            cpu_halt_q <= cpu_halt_d;
        end
    end

    assign hdma_gnt = hdma_gnt_q;
    assign cpu_halt = cpu_halt_q;

    // -------------------------------------------------------------------------
    // Bus mux, combinational from the registered owner.
    // -------------------------------------------------------------------------
    always_comb begin
        bus_rd   = 1'b0;
        bus_wr   = 1'b0;
        bus_a    = 16'h0000;
        bus_dout = 8'h00;

        unique case (owner_q)
            OWN_OAM: begin
                bus_rd   = dma_rd;
                bus_wr   = dma_wr;
                bus_a    = dma_a;
                bus_dout = dma_dout;
            end
            OWN_HDMA: begin
                bus_rd   = hdma_rd;
                bus_wr   = hdma_wr;
                bus_a    = hdma_a;
                bus_dout = hdma_dout;
            end
            default: begin
                if (!cpu_in_io) begin
                    bus_rd   = cpu_rd;
                    bus_wr   = cpu_wr;
                    bus_a    = cpu_a;
                    bus_dout = cpu_dout;
                end
            end
        endcase
    end

    // Both engines read straight from the bus. They only act on the data
    // while they own it.
    assign dma_din  = bus_din;
    assign hdma_din = bus_din;

    // -------------------------------------------------------------------------
    // CPU read data. IO/HRAM is always reachable. Below FF00 the CPU sees
    // conflict data while OAM DMA holds the bus. Blocked CPU writes need no
    // logic here, because the bus is already driven by the DMA engine.
    // -------------------------------------------------------------------------
    always_comb begin
        if (cpu_in_io) begin
            cpu_din = io_din;
        end else if (owner_q == OWN_OAM) begin
`ifdef BUS_ARB_DMG_CORRUPT_EN
            cpu_din = bus_din;
`else
            cpu_din = CONFLICT_DATA;
`endif
        end else begin
            cpu_din = bus_din;
        end
    end

endmodule
